// File: rtl/id_ex_bypass_pipe.sv
// Decode->execute pipeline register with operand forwarding, bubble insertion and store-data register.
// Optional PIPE_PERF_COUNTERS_EN adds stall, bubble and bypass event counters.

package id_ex_bypass_pkg;

    typedef struct packed {
        logic [3:0] ctrl;
        logic [4:0] rs_addr;
        logic [4:0] rt_addr;
        logic [4:0] rd_addr;
    } id_ex_ctrl_t;

endpackage

module id_ex_bypass_pipe
    import id_ex_bypass_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_STALL = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_stall,
    input  logic              w_flush,
    input  logic              w_me_rs_bypass,
    input  logic              w_me_rt_bypass,
    input  logic              w_we_rs_bypass,
    input  logic              w_we_rt_bypass,
    input  logic              w_wm_rt_bypass,
    input  logic [3:0]        w_dctrl_4,
    input  logic [4:0]        w_drs_addr_5,
    input  logic [4:0]        w_drt_addr_5,
    input  logic [4:0]        w_drd_addr_5,
    input  logic [DATA_W-1:0] w_drs_data,
    input  logic [DATA_W-1:0] w_drt_data,
    input  logic [DATA_W-1:0] w_ex_result,
    input  logic [DATA_W-1:0] w_wb_data,
    output logic              w_fd_enable,
    output logic              w_evalid,
    output logic [3:0]        w_ectrl_4,
    output logic [4:0]        w_ers_addr_5,
    output logic [4:0]        w_ert_addr_5,
    output logic [4:0]        w_erd_addr_5,
    output logic [DATA_W-1:0] w_ers_data,
    output logic [DATA_W-1:0] w_ert_data,
    output logic [DATA_W-1:0] w_mstore_data,
`ifdef PIPE_PERF_COUNTERS_EN
    output logic [31:0]       w_stall_count,
    output logic [31:0]       w_bubble_count,
    output logic [31:0]       w_bypass_count,
`endif
    output logic              w_stall_error
);

    localparam int CNT_W = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_STALL + 1);

    logic              bubble;
    logic              any_bypass;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    id_ex_ctrl_t       de_d;
    id_ex_ctrl_t       de_q;
    logic              evalid_q;
    logic [DATA_W-1:0] ers_q;
    logic [DATA_W-1:0] ert_q;
    logic [DATA_W-1:0] mstore_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              stall_err_q;

    // Flush wins over stall: the branch redirect must refetch.
    assign bubble      = w_stall | w_flush;
    assign w_fd_enable = ~w_stall | w_flush;
    assign any_bypass  = w_me_rs_bypass | w_me_rt_bypass |
                         w_we_rs_bypass | w_we_rt_bypass;

    always_comb begin
        rs_fwd = w_drs_data;
        priority case (1'b1)
            w_me_rs_bypass: rs_fwd = w_ex_result;
            w_we_rs_bypass: rs_fwd = w_wb_data;
            default:        rs_fwd = w_drs_data;
        endcase
    end

    always_comb begin
        rt_fwd = w_drt_data;
        priority case (1'b1)
            w_me_rt_bypass: rt_fwd = w_ex_result;
            w_we_rt_bypass: rt_fwd = w_wb_data;
            default:        rt_fwd = w_drt_data;
        endcase
    end

    always_comb begin
        de_d         = '0;
        de_d.ctrl    = w_dctrl_4;
        de_d.rs_addr = w_drs_addr_5;
        de_d.rt_addr = w_drt_addr_5;
        de_d.rd_addr = w_drd_addr_5;
    end

    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            de_q     <= '0;
            evalid_q <= 1'b0;
            ers_q    <= '0;
            ert_q    <= '0;
        end else begin
            de_q     <= de_d;
            evalid_q <= 1'b1;
            ers_q    <= rs_fwd;
            ert_q    <= rt_fwd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_flush) begin
            mstore_q <= '0;
        end else if (w_wm_rt_bypass) begin
            mstore_q <= w_wb_data;
        end else begin
            mstore_q <= ert_q;
        end
    end

    // A stall that coincides with a flush neither counts nor clears.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!w_stall) begin
            stall_cnt_d = '0;
        end else if (!w_flush && stall_cnt_q != CNT_SAT) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_q | (stall_cnt_d == CNT_SAT);
        end
    end

`ifdef PIPE_PERF_COUNTERS_EN
    logic [31:0] stall_count_q;
    logic [31:0] bubble_count_q;
    logic [31:0] bypass_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q  <= '0;
            bubble_count_q <= '0;
            bypass_count_q <= '0;
        end else begin
            if (w_stall && !w_flush) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (bubble) begin
                bubble_count_q <= bubble_count_q + 32'd1;
            end
            if (!bubble && any_bypass) begin
                bypass_count_q <= bypass_count_q + 32'd1;
            end
        end
    end

    assign w_stall_count  = stall_count_q;
    assign w_bubble_count = bubble_count_q;
    assign w_bypass_count = bypass_count_q;
`else
    logic unused_bypass;
    assign unused_bypass = any_bypass;
`endif

    assign w_evalid      = evalid_q;
    assign w_ectrl_4     = de_q.ctrl;
    assign w_ers_addr_5  = de_q.rs_addr;
    assign w_ert_addr_5  = de_q.rt_addr;
    assign w_erd_addr_5  = de_q.rd_addr;
    assign w_ers_data    = ers_q;
    assign w_ert_data    = ert_q;
    assign w_mstore_data = mstore_q;
    assign w_stall_error = stall_err_q;

endmodule

// File: tb/tb_id_ex_bypass_pipe.sv
// Randomized bench for id_ex_bypass_pipe against a cycle-level reference model.
// Directed literal checks pin the model for the main scenarios.

module tb_id_ex_bypass_pipe;

    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          w_stall, w_flush;
    logic          w_me_rs_bypass, w_me_rt_bypass;
    logic          w_we_rs_bypass, w_we_rt_bypass, w_wm_rt_bypass;
    logic [3:0]    w_dctrl_4;
    logic [4:0]    w_drs_addr_5, w_drt_addr_5, w_drd_addr_5;
    logic [DW-1:0] w_drs_data, w_drt_data, w_ex_result, w_wb_data;
    logic          w_fd_enable, w_evalid, w_stall_error;
    logic [3:0]    w_ectrl_4;
    logic [4:0]    w_ers_addr_5, w_ert_addr_5, w_erd_addr_5;
    logic [DW-1:0] w_ers_data, w_ert_data, w_mstore_data;
`ifdef PIPE_PERF_COUNTERS_EN
    logic [31:0]   w_stall_count, w_bubble_count, w_bypass_count;
`endif

    always #5 clock = ~clock;

    id_ex_bypass_pipe #(.DATA_W(DW), .MAX_STALL(MAXS)) dut (
        .clock(clock), .reset(reset),
        .w_stall(w_stall), .w_flush(w_flush),
        .w_me_rs_bypass(w_me_rs_bypass), .w_me_rt_bypass(w_me_rt_bypass),
        .w_we_rs_bypass(w_we_rs_bypass), .w_we_rt_bypass(w_we_rt_bypass),
        .w_wm_rt_bypass(w_wm_rt_bypass),
        .w_dctrl_4(w_dctrl_4),
        .w_drs_addr_5(w_drs_addr_5), .w_drt_addr_5(w_drt_addr_5),
        .w_drd_addr_5(w_drd_addr_5),
        .w_drs_data(w_drs_data), .w_drt_data(w_drt_data),
        .w_ex_result(w_ex_result), .w_wb_data(w_wb_data),
        .w_fd_enable(w_fd_enable), .w_evalid(w_evalid),
        .w_ectrl_4(w_ectrl_4),
        .w_ers_addr_5(w_ers_addr_5), .w_ert_addr_5(w_ert_addr_5),
        .w_erd_addr_5(w_erd_addr_5),
        .w_ers_data(w_ers_data), .w_ert_data(w_ert_data),
        .w_mstore_data(w_mstore_data),
`ifdef PIPE_PERF_COUNTERS_EN
        .w_stall_count(w_stall_count), .w_bubble_count(w_bubble_count),
        .w_bypass_count(w_bypass_count),
`endif
        .w_stall_error(w_stall_error)
    );

    typedef struct {
        bit         rst, stall, flush;
        bit         me_rs, me_rt, we_rs, we_rt, wm_rt;
        logic [3:0] ctrl;
        logic [4:0] rs, rt, rd;
        logic [31:0] rsd, rtd, exr, wbd;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: what the execute/memory stages must hold.
    bit          m_evalid, m_err;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_ers, m_ert, m_ms;
    int          m_run;
    logic [31:0] m_sc, m_bc, m_pc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic model_step(input vec_t v);
        logic [31:0] ms_n;
        if (v.rst) begin
            {m_evalid, m_err, m_ctrl, m_rs, m_rt, m_rd} = '0;
            m_ers = 0; m_ert = 0; m_ms = 0; m_run = 0;
            m_sc = 0; m_bc = 0; m_pc = 0;
            return;
        end
        ms_n = v.flush ? 32'd0 : (v.wm_rt ? v.wbd : m_ert);
        if (v.stall && !v.flush) m_sc++;
        if (v.stall || v.flush) begin
            m_bc++;
            m_evalid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0;
            m_ers = 0; m_ert = 0;
        end else begin
            if (v.me_rs || v.me_rt || v.we_rs || v.we_rt) m_pc++;
            m_evalid = 1; m_ctrl = v.ctrl;
            m_rs = v.rs; m_rt = v.rt; m_rd = v.rd;
            m_ers = v.me_rs ? v.exr : (v.we_rs ? v.wbd : v.rsd);
            m_ert = v.me_rt ? v.exr : (v.we_rt ? v.wbd : v.rtd);
        end
        m_ms = ms_n;
        if (!v.stall) m_run = 0;
        else if (!v.flush && m_run <= MAXS) m_run++;
        if (m_run > MAXS) m_err = 1;
    endtask

    task automatic compare_all();
        chk("evalid", 32'(w_evalid), 32'(m_evalid));
        chk("ectrl", 32'(w_ectrl_4), 32'(m_ctrl));
        chk("ers_addr", 32'(w_ers_addr_5), 32'(m_rs));
        chk("ert_addr", 32'(w_ert_addr_5), 32'(m_rt));
        chk("erd_addr", 32'(w_erd_addr_5), 32'(m_rd));
        chk("ers_data", w_ers_data, m_ers);
        chk("ert_data", w_ert_data, m_ert);
        chk("mstore", w_mstore_data, m_ms);
        chk("stall_err", 32'(w_stall_error), 32'(m_err));
`ifdef PIPE_PERF_COUNTERS_EN
        chk("stall_cnt", w_stall_count, m_sc);
        chk("bubble_cnt", w_bubble_count, m_bc);
        chk("bypass_cnt", w_bypass_count, m_pc);
`endif
    endtask

    // Drive one cycle, check the combinational enable, clock, check state.
    task automatic apply(input vec_t v);
        reset = v.rst; w_stall = v.stall; w_flush = v.flush;
        w_me_rs_bypass = v.me_rs; w_me_rt_bypass = v.me_rt;
        w_we_rs_bypass = v.we_rs; w_we_rt_bypass = v.we_rt;
        w_wm_rt_bypass = v.wm_rt; w_dctrl_4 = v.ctrl;
        w_drs_addr_5 = v.rs; w_drt_addr_5 = v.rt; w_drd_addr_5 = v.rd;
        w_drs_data = v.rsd; w_drt_data = v.rtd;
        w_ex_result = v.exr; w_wb_data = v.wbd;
        #1;
        chk("fd_enable", 32'(w_fd_enable), 32'(!v.stall || v.flush));
        model_step(v);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    function automatic vec_t instr();
        vec_t v;
        v = idle();
        v.ctrl = 4'b1000; v.rs = 5'd3; v.rt = 5'd4; v.rd = 5'd5;
        v.rsd = 32'h11; v.rtd = 32'h22;
        return v;
    endfunction

    initial begin
        vec_t v;
        int burst;
        m_run = 0;
        v = idle(); v.rst = 1;
        apply(v); apply(v);
        chk("lit_rst_evalid", 32'(w_evalid), 32'd0);
        chk("lit_rst_mstore", w_mstore_data, 32'd0);
        for (int i = 0; i < 3; i++) apply(idle());
        chk("lit_idle_ctrl", 32'(w_ectrl_4), 32'd0);
        chk("lit_idle_ers", w_ers_data, 32'd0);
        chk("lit_idle_fden", 32'(w_fd_enable), 32'd1);
        chk("lit_idle_err", 32'(w_stall_error), 32'd0);

        apply(instr());
        chk("lit_load_evalid", 32'(w_evalid), 32'd1);
        chk("lit_load_ers", w_ers_data, 32'h11);
        chk("lit_load_ert", w_ert_data, 32'h22);
        chk("lit_load_erd", 32'(w_erd_addr_5), 32'd5);

        v = instr(); v.me_rs = 1; v.we_rs = 1;
        v.exr = 32'hAA; v.wbd = 32'hBB;
        apply(v);
        chk("lit_me_prio", w_ers_data, 32'hAA);
        v = instr(); v.we_rt = 1; v.exr = 32'hAA; v.wbd = 32'hBB;
        apply(v);
        chk("lit_we_rt", w_ert_data, 32'hBB);
        chk("lit_we_rt_rs", w_ers_data, 32'h11);

        v = instr(); v.stall = 1;
        apply(v);
        chk("lit_stall_evalid", 32'(w_evalid), 32'd0);
        chk("lit_stall_ctrl", 32'(w_ectrl_4), 32'd0);
        apply(instr());
        chk("lit_resume_evalid", 32'(w_evalid), 32'd1);
        chk("lit_resume_ctrl", 32'(w_ectrl_4), 32'b1000);

        v = instr(); v.stall = 1; v.flush = 1; v.me_rs = 1; v.exr = 32'h5;
        apply(v);
        chk("lit_sf_evalid", 32'(w_evalid), 32'd0);
        chk("lit_sf_ers", w_ers_data, 32'd0);
        v = instr(); v.stall = 1;
        for (int i = 0; i < 4; i++) apply(v);
        chk("lit_stall4_err", 32'(w_stall_error), 32'd0);
        apply(v);
        chk("lit_stall5_err", 32'(w_stall_error), 32'd1);
        apply(instr());
        chk("lit_err_sticky", 32'(w_stall_error), 32'd1);

        v = instr(); v.rtd = 32'h33;
        apply(v);
        v.wm_rt = 1; v.wbd = 32'h44;
        apply(v);
        chk("lit_wm_store", w_mstore_data, 32'h44);
        v.wm_rt = 0;
        apply(v);
        chk("lit_ert_store", w_mstore_data, 32'h33);

        v = idle(); v.rst = 1; v.stall = 1;
        apply(v);
        chk("lit_rst_err", 32'(w_stall_error), 32'd0);

        burst = 0;
        for (int c = 0; c < 600; c++) begin
            v = idle();
            v.rst = ($urandom_range(0, 99) == 0);
            if (burst > 0) begin
                v.stall = 1; burst--;
            end else if ($urandom_range(0, 7) == 0) begin
                burst = $urandom_range(1, 7); v.stall = 1;
            end
            v.flush = ($urandom_range(0, 5) == 0);
            v.me_rs = ($urandom_range(0, 2) == 0);
            v.me_rt = ($urandom_range(0, 2) == 0);
            v.we_rs = ($urandom_range(0, 2) == 0);
            v.we_rt = ($urandom_range(0, 2) == 0);
            v.wm_rt = ($urandom_range(0, 2) == 0);
            v.ctrl = 4'($urandom); v.rs = 5'($urandom);
            v.rt = 5'($urandom); v.rd = 5'($urandom);
            v.rsd = $urandom; v.rtd = $urandom;
            v.exr = $urandom; v.wbd = $urandom;
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
